// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared types for the memory-access stage, write-back, hazard
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned REG_AW_DEF  = 5;
   localparam int unsigned TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      EXC_NONE     = 2'd0,
      EXC_OVERFLOW = 2'd1,
      EXC_MISALIGN = 2'd2,
      EXC_TIMEOUT  = 2'd3
   } exc_code_e;

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
// ============================================================================
// mem_access_stage_if : req/ack data-memory bus between stage and memory
// Revision            : 1.0
// ============================================================================
`default_nettype none

interface mem_access_stage_if #(
   parameter int DATA_W = 32
) ();

   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

`default_nettype wire

// File: rtl/bus_timeout_counter.sv
// ============================================================================
// bus_timeout_counter : 8-bit wait counter, flags the cycle that reaches TIMEOUT
// Revision            : 1.0
// ============================================================================
`default_nettype none

module bus_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  wire logic clock,
   input  wire logic reset,
   input  wire logic clear_i,
   input  wire logic enable_i,
   output logic      expired_o
);

   localparam logic [7:0] C_LIMIT = 8'(TIMEOUT);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)
         count_d = '0;
      else if (enable_i)
         count_d = count_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   // Combinational so the owner can leave its wait state on this very edge.
   assign expired_o = enable_i && !clear_i && (count_d == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : registers EX results, runs load/store bus transactions
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 16
) (
   input  wire logic              clock,
   input  wire logic              reset,
   input  wire logic              ex_valid,
   input  wire logic [DATA_W-1:0] alu_result,
   input  wire logic              alu_overflow,
   input  wire logic              alu_zero,
   input  wire logic [DATA_W-1:0] store_data,
   input  wire logic              mem_read,
   input  wire logic              mem_write,
   input  wire logic              reg_write,
   input  wire logic              trap_on_ovf,
   input  wire logic [REG_AW-1:0] rd,
   output logic                   freeze,
   mem_access_stage_if.master     mem_bus,
   output logic                   wb_valid,
   output logic                   wb_reg_write,
   output logic [REG_AW-1:0]      wb_rd,
   output logic [DATA_W-1:0]      wb_data,
   output logic                   wb_zero,
   output logic                   exc_valid,
   output logic [1:0]             exc_code
);

   mem_state_e        state_q,     state_d;
   logic              freeze_q,    freeze_d;
   logic              req_q,       req_d;
   logic              we_q,        we_d;
   logic [DATA_W-1:0] addr_q,      addr_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic              wb_valid_q,  wb_valid_d;
   logic              wb_rw_q,     wb_rw_d;
   logic [REG_AW-1:0] wb_rd_q,     wb_rd_d;
   logic [DATA_W-1:0] wb_data_q,   wb_data_d;
   logic              wb_zero_q,   wb_zero_d;
   logic              exc_valid_q, exc_valid_d;
   exc_code_e         exc_code_q,  exc_code_d;
   logic              rw_pend_q,   rw_pend_d;
   logic [REG_AW-1:0] rd_pend_q,   rd_pend_d;
   logic              zero_pend_q, zero_pend_d;

   logic w_in_access;
   logic w_expired;
   logic w_trap;

   assign w_in_access = (state_q == ST_ACCESS);
   assign w_trap      = alu_overflow && trap_on_ovf;

   bus_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (!w_in_access),
      .enable_i  (w_in_access && !mem_bus.mem_ack),
      .expired_o (w_expired)
   );

   always_comb begin
      state_d     = state_q;
      freeze_d    = freeze_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wb_valid_d  = 1'b0;
      wb_rw_d     = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      wb_zero_d   = wb_zero_q;
      exc_valid_d = 1'b0;
      exc_code_d  = EXC_NONE;
      rw_pend_d   = rw_pend_q;
      rd_pend_d   = rd_pend_q;
      zero_pend_d = zero_pend_q;

      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               if ((mem_read || mem_write) && (alu_result[1:0] == 2'b00)) begin
                  state_d     = ST_ACCESS;
                  freeze_d    = 1'b1;
                  req_d       = 1'b1;
                  we_d        = mem_write;
                  addr_d      = alu_result;
                  wdata_d     = store_data;
                  rw_pend_d   = reg_write;
                  rd_pend_d   = rd;
                  zero_pend_d = alu_zero;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd;
                  wb_data_d  = alu_result;
                  wb_zero_d  = alu_zero;
                  if (mem_read || mem_write) begin
                     exc_valid_d = 1'b1;
                     exc_code_d  = EXC_MISALIGN;
                  end else begin
                     wb_rw_d = reg_write && !w_trap;
                     if (w_trap) begin
                        exc_valid_d = 1'b1;
                        exc_code_d  = EXC_OVERFLOW;
                     end
                  end
               end
            end
         end

         ST_ACCESS: begin
            // An ack on the expiry cycle still completes the access normally.
            if (mem_bus.mem_ack || w_expired) begin
               state_d    = ST_RESP;
               freeze_d   = 1'b0;
               req_d      = 1'b0;
               we_d       = 1'b0;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_pend_q;
               wb_zero_d  = zero_pend_q;
               wb_data_d  = (mem_bus.mem_ack && !we_q) ? mem_bus.mem_rdata : addr_q;
               wb_rw_d    = mem_bus.mem_ack && rw_pend_q && !we_q;
               if (!mem_bus.mem_ack) begin
                  exc_valid_d = 1'b1;
                  exc_code_d  = EXC_TIMEOUT;
               end
            end
         end

         ST_RESP: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         freeze_q    <= 1'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wb_valid_q  <= 1'b0;
         wb_rw_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         wb_zero_q   <= 1'b0;
         exc_valid_q <= 1'b0;
         exc_code_q  <= EXC_NONE;
         rw_pend_q   <= 1'b0;
         rd_pend_q   <= '0;
         zero_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         freeze_q    <= freeze_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wb_valid_q  <= wb_valid_d;
         wb_rw_q     <= wb_rw_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         wb_zero_q   <= wb_zero_d;
         exc_valid_q <= exc_valid_d;
         exc_code_q  <= exc_code_d;
         rw_pend_q   <= rw_pend_d;
         rd_pend_q   <= rd_pend_d;
         zero_pend_q <= zero_pend_d;
      end
   end

   assign freeze            = freeze_q;
   assign mem_bus.mem_req   = req_q;
   assign mem_bus.mem_we    = we_q;
   assign mem_bus.mem_addr  = addr_q;
   assign mem_bus.mem_wdata = wdata_q;
   assign wb_valid          = wb_valid_q;
   assign wb_reg_write      = wb_rw_q;
   assign wb_rd             = wb_rd_q;
   assign wb_data           = wb_data_q;
   assign wb_zero           = wb_zero_q;
   assign exc_valid         = exc_valid_q;
   assign exc_code          = exc_code_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : directed checks of the memory-access stage
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

   logic        clock;
   logic        reset;
   logic        ex_valid;
   logic [31:0] alu_result;
   logic        alu_overflow;
   logic        alu_zero;
   logic [31:0] store_data;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        trap_on_ovf;
   logic [4:0]  rd;
   logic        freeze;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_zero;
   logic        exc_valid;
   logic [1:0]  exc_code;

   int n_cmp = 0;
   int n_err = 0;

   mem_access_stage_if #(.DATA_W(32)) bus ();

   mem_access_stage #(
      .DATA_W  (32),
      .REG_AW  (5),
      .TIMEOUT (16)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .ex_valid     (ex_valid),
      .alu_result   (alu_result),
      .alu_overflow (alu_overflow),
      .alu_zero     (alu_zero),
      .store_data   (store_data),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .reg_write    (reg_write),
      .trap_on_ovf  (trap_on_ovf),
      .rd           (rd),
      .freeze       (freeze),
      .mem_bus      (bus),
      .wb_valid     (wb_valid),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_zero      (wb_zero),
      .exc_valid    (exc_valid),
      .exc_code     (exc_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; returns 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid     = 1'b0;
      alu_result   = '0;
      alu_overflow = 1'b0;
      alu_zero     = 1'b0;
      store_data   = '0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      trap_on_ovf  = 1'b0;
      rd           = '0;
   endtask

   initial begin
      logic [31:0] vals [3];
      int          n_req;

      vals[0] = 32'd5;
      vals[1] = 32'd7;
      vals[2] = 32'd9;

      idle_inputs();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      reset         = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_freeze",   32'(freeze),      32'd0);
      chk("rst_req",      32'(bus.mem_req), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid),    32'd0);
      chk("rst_exc",      32'(exc_valid),   32'd0);
      chk("rst_wb_data",  wb_data,          32'd0);

      // Back-to-back ALU ops, one per cycle
      for (int i = 0; i < 3; i++) begin
         ex_valid   = 1'b1;
         reg_write  = 1'b1;
         alu_result = vals[i];
         rd         = 5'(i + 1);
         tick();
         chk("b2b_valid",  32'(wb_valid),     32'd1);
         chk("b2b_data",   wb_data,           vals[i]);
         chk("b2b_rd",     32'(wb_rd),        32'(i + 1));
         chk("b2b_rw",     32'(wb_reg_write), 32'd1);
         chk("b2b_freeze", 32'(freeze),       32'd0);
      end
      idle_inputs();
      tick();
      chk("b2b_end_valid", 32'(wb_valid), 32'd0);

      // Zero flag forwarding
      ex_valid = 1'b1;
      alu_zero = 1'b1;
      tick();
      chk("zero_flag", 32'(wb_zero), 32'd1);
      idle_inputs();
      tick();

      // Load, ack on the 3rd ACCESS cycle; ex_valid held while frozen
      ex_valid   = 1'b1;
      mem_read   = 1'b1;
      reg_write  = 1'b1;
      alu_result = 32'h100;
      rd         = 5'd3;
      tick();
      chk("ld_req",   32'(bus.mem_req), 32'd1);
      chk("ld_we",    32'(bus.mem_we),  32'd0);
      chk("ld_addr",  bus.mem_addr,     32'h100);
      chk("ld_frz1",  32'(freeze),      32'd1);
      tick();
      chk("ld_frz2",  32'(freeze),      32'd1);
      chk("ld_nowb",  32'(wb_valid),    32'd0);
      tick();
      chk("ld_frz3",  32'(freeze),      32'd1);
      chk("ld_req3",  32'(bus.mem_req), 32'd1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      idle_inputs();
      tick();
      bus.mem_ack = 1'b0;
      chk("ld_resp_frz",   32'(freeze),       32'd0);
      chk("ld_resp_req",   32'(bus.mem_req),  32'd0);
      chk("ld_resp_valid", 32'(wb_valid),     32'd1);
      chk("ld_resp_data",  wb_data,           32'hDEADBEEF);
      chk("ld_resp_rw",    32'(wb_reg_write), 32'd1);
      chk("ld_resp_rd",    32'(wb_rd),        32'd3);
      chk("ld_resp_exc",   32'(exc_valid),    32'd0);
      tick();
      chk("ld_after_valid", 32'(wb_valid), 32'd0);

      // Store with immediate ack
      ex_valid   = 1'b1;
      mem_write  = 1'b1;
      reg_write  = 1'b1;
      alu_result = 32'h20;
      store_data = 32'h1234;
      tick();
      chk("st_req",   32'(bus.mem_req), 32'd1);
      chk("st_we",    32'(bus.mem_we),  32'd1);
      chk("st_addr",  bus.mem_addr,     32'h20);
      chk("st_wdata", bus.mem_wdata,    32'h1234);
      idle_inputs();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("st_valid", 32'(wb_valid),     32'd1);
      chk("st_rw",    32'(wb_reg_write), 32'd0);
      chk("st_data",  wb_data,           32'h20);
      tick();

      // Read and write together behave as a store
      ex_valid   = 1'b1;
      mem_read   = 1'b1;
      mem_write  = 1'b1;
      reg_write  = 1'b1;
      alu_result = 32'h30;
      tick();
      chk("rw_both_we", 32'(bus.mem_we), 32'd1);
      idle_inputs();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("rw_both_rw", 32'(wb_reg_write), 32'd0);
      tick();

      // Overflow with and without trapping
      ex_valid     = 1'b1;
      reg_write    = 1'b1;
      alu_overflow = 1'b1;
      trap_on_ovf  = 1'b1;
      alu_result   = 32'h8000_0000;
      tick();
      chk("ovf_exc",   32'(exc_valid),    32'd1);
      chk("ovf_code",  32'(exc_code),     32'd1);
      chk("ovf_rw",    32'(wb_reg_write), 32'd0);
      chk("ovf_valid", 32'(wb_valid),     32'd1);
      trap_on_ovf = 1'b0;
      tick();
      chk("ovfnt_exc",  32'(exc_valid),    32'd0);
      chk("ovfnt_code", 32'(exc_code),     32'd0);
      chk("ovfnt_rw",   32'(wb_reg_write), 32'd1);
      idle_inputs();
      tick();

      // Misaligned load
      ex_valid   = 1'b1;
      mem_read   = 1'b1;
      reg_write  = 1'b1;
      alu_result = 32'h102;
      tick();
      chk("mis_req",   32'(bus.mem_req),  32'd0);
      chk("mis_valid", 32'(wb_valid),     32'd1);
      chk("mis_rw",    32'(wb_reg_write), 32'd0);
      chk("mis_exc",   32'(exc_valid),    32'd1);
      chk("mis_code",  32'(exc_code),     32'd2);
      chk("mis_frz",   32'(freeze),       32'd0);
      idle_inputs();
      tick();
      chk("mis_req2",  32'(bus.mem_req),  32'd0);

      // Stray ack while idle is ignored
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("idle_ack_valid", 32'(wb_valid), 32'd0);

      // Load that is never acknowledged
      ex_valid   = 1'b1;
      mem_read   = 1'b1;
      reg_write  = 1'b1;
      alu_result = 32'h40;
      tick();
      idle_inputs();
      n_req = 0;
      while (bus.mem_req && n_req < 40) begin
         n_req++;
         tick();
      end
      chk("tmo_req_cycles", 32'(n_req),        32'd16);
      chk("tmo_valid",      32'(wb_valid),     32'd1);
      chk("tmo_exc",        32'(exc_valid),    32'd1);
      chk("tmo_code",       32'(exc_code),     32'd3);
      chk("tmo_rw",         32'(wb_reg_write), 32'd0);
      chk("tmo_frz",        32'(freeze),       32'd0);
      tick();

      // Reset in the 2nd ACCESS cycle aborts the transaction
      ex_valid   = 1'b1;
      mem_read   = 1'b1;
      reg_write  = 1'b1;
      alu_result = 32'h80;
      tick();
      idle_inputs();
      tick();
      chk("rstmid_req_before", 32'(bus.mem_req), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstmid_req",   32'(bus.mem_req), 32'd0);
      chk("rstmid_frz",   32'(freeze),      32'd0);
      chk("rstmid_valid", 32'(wb_valid),    32'd0);
      tick();
      chk("rstmid_valid2", 32'(wb_valid),  32'd0);
      chk("rstmid_exc2",   32'(exc_valid), 32'd0);
      ex_valid   = 1'b1;
      reg_write  = 1'b1;
      alu_result = 32'h55;
      tick();
      chk("rstmid_resume", wb_data, 32'h55);
      idle_inputs();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
